// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: one shared period counter, NUM_CH compare channels,
// double-buffered configuration applied only at a period boundary (or while idle).
module pwm_gen_multi #(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      cfg_load,
    input  logic [CNT_W-1:0]          cfg_period,
    input  logic [NUM_CH-1:0]         cfg_ch_en,
    input  logic [NUM_CH-1:0]         cfg_pol,
    input  logic [2*NUM_CH-1:0]       cfg_mode,
    input  logic [CNT_W*NUM_CH-1:0]   cfg_cmp1,
    input  logic [CNT_W*NUM_CH-1:0]   cfg_cmp2,
    output logic                      cfg_pending,
    output logic [CNT_W-1:0]          count_val,
    output logic                      period_end,
    output logic [NUM_CH-1:0]         pwm_out
);

    logic [CNT_W-1:0]        sh_period_q, act_period_q, act_period_d;
    logic [NUM_CH-1:0]       sh_ch_en_q, act_ch_en_q, act_ch_en_d;
    logic [NUM_CH-1:0]       sh_pol_q, act_pol_q, act_pol_d;
    logic [2*NUM_CH-1:0]     sh_mode_q, act_mode_q, act_mode_d;
    logic [CNT_W*NUM_CH-1:0] sh_cmp1_q, act_cmp1_q, act_cmp1_d;
    logic [CNT_W*NUM_CH-1:0] sh_cmp2_q, act_cmp2_q, act_cmp2_d;
    logic                    pending_q, pending_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pe_q, pe_d;
    logic [NUM_CH-1:0]       pwm_q, pwm_d;
    logic                    wrap, xfer;

    // Raw channel level before enable gating and polarity.
    function automatic logic raw_cmp(input logic [1:0] mode, input logic [CNT_W-1:0] c1,
                                     input logic [CNT_W-1:0] c2, input logic [CNT_W-1:0] cnt);
        logic r;
        r = 1'b0;
        if (c1 != c2) begin
            case (mode)
                2'b00:   r = (cnt <= c1) && (c1 != '0);
                2'b01:   r = (cnt >= c1);
                default: r = (c1 <= cnt) && (cnt < c2);
            endcase
        end
        return r;
    endfunction

    always_comb begin
        wrap      = (cnt_q == act_period_q);
        cnt_d     = '0;
        pe_d      = 1'b0;
        if (en) begin
            if (wrap) begin
                pe_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Transfer samples the shadow before any same-edge load overwrites it.
        xfer         = pending_q && (!en || wrap);
        act_period_d = xfer ? sh_period_q : act_period_q;
        act_ch_en_d  = xfer ? sh_ch_en_q  : act_ch_en_q;
        act_pol_d    = xfer ? sh_pol_q    : act_pol_q;
        act_mode_d   = xfer ? sh_mode_q   : act_mode_q;
        act_cmp1_d   = xfer ? sh_cmp1_q   : act_cmp1_q;
        act_cmp2_d   = xfer ? sh_cmp2_q   : act_cmp2_q;
        pending_d    = cfg_load ? 1'b1 : (xfer ? 1'b0 : pending_q);

        pwm_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = act_pol_q[i] ^ (raw_cmp(act_mode_q[2*i +: 2],
                                               act_cmp1_q[CNT_W*i +: CNT_W],
                                               act_cmp2_q[CNT_W*i +: CNT_W],
                                               cnt_q) & act_ch_en_q[i] & en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_period_q  <= '0;
            sh_ch_en_q   <= '0;
            sh_pol_q     <= '0;
            sh_mode_q    <= '0;
            sh_cmp1_q    <= '0;
            sh_cmp2_q    <= '0;
            act_period_q <= '0;
            act_ch_en_q  <= '0;
            act_pol_q    <= '0;
            act_mode_q   <= '0;
            act_cmp1_q   <= '0;
            act_cmp2_q   <= '0;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            pe_q         <= 1'b0;
            pwm_q        <= '0;
        end else begin
            if (cfg_load) begin
                sh_period_q <= cfg_period;
                sh_ch_en_q  <= cfg_ch_en;
                sh_pol_q    <= cfg_pol;
                sh_mode_q   <= cfg_mode;
                sh_cmp1_q   <= cfg_cmp1;
                sh_cmp2_q   <= cfg_cmp2;
            end
            act_period_q <= act_period_d;
            act_ch_en_q  <= act_ch_en_d;
            act_pol_q    <= act_pol_d;
            act_mode_q   <= act_mode_d;
            act_cmp1_q   <= act_cmp1_d;
            act_cmp2_q   <= act_cmp2_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            pe_q         <= pe_d;
            pwm_q        <= pwm_d;
        end
    end

    assign cfg_pending = pending_q;
    assign count_val   = cnt_q;
    assign period_end  = pe_q;
    assign pwm_out     = pwm_q;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Bench for pwm_gen_multi: directed scenarios then random traffic, every cycle
// compared against a reference model built from the behavioural rules.
module tb_pwm_gen_multi;
    localparam int CW = 16;
    localparam int NC = 4;

    logic           clk = 1'b0;
    logic           rst, en, cfg_load;
    logic [CW-1:0]  cfg_period;
    logic [NC-1:0]  cfg_ch_en, cfg_pol;
    logic [2*NC-1:0] cfg_mode;
    logic [CW*NC-1:0] cfg_cmp1, cfg_cmp2;
    logic           cfg_pending, period_end;
    logic [CW-1:0]  count_val;
    logic [NC-1:0]  pwm_out;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [CW-1:0]    period;
        logic [NC-1:0]    ch_en;
        logic [NC-1:0]    pol;
        logic [2*NC-1:0]  mode;
        logic [CW*NC-1:0] cmp1;
        logic [CW*NC-1:0] cmp2;
    } cfg_t;

    cfg_t          m_sh, m_act;
    logic          m_pend, m_pe;
    logic [CW-1:0] m_cnt;
    logic [NC-1:0] m_pwm;

    pwm_gen_multi #(.CNT_W(CW), .NUM_CH(NC)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load),
        .cfg_period(cfg_period), .cfg_ch_en(cfg_ch_en), .cfg_pol(cfg_pol),
        .cfg_mode(cfg_mode), .cfg_cmp1(cfg_cmp1), .cfg_cmp2(cfg_cmp2),
        .cfg_pending(cfg_pending), .count_val(count_val),
        .period_end(period_end), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    function automatic logic ref_level(cfg_t c, int ch, logic [CW-1:0] cnt);
        logic [CW-1:0] c1, c2;
        logic [1:0]    md;
        c1 = c.cmp1[CW*ch +: CW];
        c2 = c.cmp2[CW*ch +: CW];
        md = c.mode[2*ch +: 2];
        if (c1 == c2) return 1'b0;
        if (md == 2'd0) return (cnt <= c1) && (c1 != 0);
        if (md == 2'd1) return cnt >= c1;
        return (c1 <= cnt) && (cnt < c2);
    endfunction

    task automatic model_reset();
        m_sh   = '{default: '0};
        m_act  = '{default: '0};
        m_pend = 1'b0;
        m_pe   = 1'b0;
        m_cnt  = '0;
        m_pwm  = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("count_val", 64'(count_val), 64'(m_cnt));
        check("period_end", 64'(period_end), 64'(m_pe));
        check("cfg_pending", 64'(cfg_pending), 64'(m_pend));
        check("pwm_out", 64'(pwm_out), 64'(m_pwm));
    endtask

    // Advance one clock: model next state from the inputs seen before the edge.
    task automatic tick();
        cfg_t          n_sh, n_act;
        logic          n_pend, n_pe, wrap, xfer;
        logic [CW-1:0] n_cnt;
        logic [NC-1:0] n_pwm;
        wrap  = (m_cnt == m_act.period);
        n_cnt = (en && !wrap) ? m_cnt + 1'b1 : '0;
        n_pe  = en && wrap;
        for (int i = 0; i < NC; i++)
            n_pwm[i] = m_act.pol[i] ^ (ref_level(m_act, i, m_cnt) && m_act.ch_en[i] && en);
        xfer   = m_pend && (!en || wrap);
        n_act  = xfer ? m_sh : m_act;
        n_sh   = m_sh;
        if (cfg_load) n_sh = '{cfg_period, cfg_ch_en, cfg_pol, cfg_mode, cfg_cmp1, cfg_cmp2};
        n_pend = cfg_load ? 1'b1 : (xfer ? 1'b0 : m_pend);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_sh = n_sh; m_act = n_act; m_pend = n_pend;
            m_cnt = n_cnt; m_pe = n_pe; m_pwm = n_pwm;
        end
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic load_tick();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
        cfg_period = '0; cfg_ch_en = '0; cfg_pol = '0; cfg_mode = '0;
        cfg_cmp1 = '0; cfg_cmp2 = '0;
        model_reset();
        run(2);
        check("reset_pwm", 64'(pwm_out), 64'd0);
        rst = 1'b0;

        // Scenario 1: left-aligned ch0, cmp1=3, period 9.
        cfg_period = 16'd9; cfg_ch_en = 4'b0001; cfg_mode = '0;
        cfg_cmp1 = 64'd3; cfg_cmp2 = '0;
        load_tick();
        tick();
        en = 1'b1;
        run(25);

        // Scenario 2: new duty loaded at cnt=2, applied from next period.
        for (int k = 0; k < 20 && m_cnt != 2; k++) tick();
        check("sync_cnt2", 64'(count_val), 64'd2);
        cfg_cmp1 = 64'd6;
        load_tick();
        check("pending_after_load", 64'(cfg_pending), 64'd1);
        run(22);

        // Scenario 3: four channels, mixed modes, ch3 inverted with equal compares.
        cfg_ch_en = 4'b1111; cfg_pol = 4'b1000; cfg_mode = 8'b10_10_01_00;
        cfg_cmp1 = {16'd5, 16'd3, 16'd7, 16'd2};
        cfg_cmp2 = {16'd5, 16'd6, 16'd0, 16'd0};
        load_tick();
        run(12);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("ch3_const", 64'(pwm_out[3]), 64'd1);
        end

        // Scenario 4: period 0, then drop en together with a polarity change.
        cfg_period = '0;
        load_tick();
        run(12);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("p0_cnt", 64'(count_val), 64'd0);
            check("p0_pe", 64'(period_end), 64'd1);
        end
        en = 1'b0; cfg_pol = 4'b0110;
        load_tick();
        run(3);
        check("idle_pol", 64'(pwm_out), 64'b0110);

        // Scenario 5: two loads in one period, only the latter applies.
        cfg_period = 16'd9; cfg_pol = '0; cfg_mode = '0; cfg_cmp1 = 64'd2; cfg_cmp2 = '0;
        load_tick();
        tick();
        en = 1'b1;
        run(3);
        cfg_cmp1 = 64'd4;
        load_tick();
        run(2);
        cfg_cmp1 = 64'd8;
        load_tick();
        run(25);

        // Scenario 6: asynchronous reset mid-period with outputs high.
        cfg_mode = 8'b00_00_00_01; cfg_cmp1 = '0; cfg_cmp2 = 64'd5; cfg_pol = 4'b0100;
        load_tick();
        run(14);
        check("pre_rst_high", 64'(pwm_out[0]), 64'd1);
        cfg_load = 1'b1;
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        cfg_load = 1'b0;
        tick();
        rst = 1'b0;
        run(5);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            int pmax;
            en = ($urandom_range(0, 19) != 0);
            cfg_load = ($urandom_range(0, 24) == 0);
            if (cfg_load) begin
                pmax = $urandom_range(0, 14);
                cfg_period = CW'(pmax);
                cfg_ch_en  = NC'($urandom);
                cfg_pol    = NC'($urandom);
                cfg_mode   = (2*NC)'($urandom);
                for (int c = 0; c < NC; c++) begin
                    cfg_cmp1[CW*c +: CW] = CW'($urandom_range(0, pmax + 2));
                    cfg_cmp2[CW*c +: CW] = CW'($urandom_range(0, pmax + 2));
                end
            end
            tick();
        end
        cfg_load = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
